// File: rtl/polar_pkg.sv
// Shared types and helpers for the successive-cancellation polar decoder control path.
package polar_pkg;

    typedef enum logic {
        OP_F = 1'b0,
        OP_G = 1'b1
    } polar_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_LLR = 3'd2,
        ST_DECIDE   = 3'd3,
        ST_FINISH   = 3'd4
    } sched_state_e;

    // Width needed to name any stage 0..counter_width-1; never narrower than one bit.
    function automatic int stage_width(input int counter_width);
        return (counter_width > 2) ? $clog2(counter_width) : 1;
    endfunction

endpackage

// File: rtl/polar_ctz.sv
// Combinational trailing-zero count; gives the tree stage at which the next bit's walk restarts.
module polar_ctz
    import polar_pkg::*;
#(
    parameter  int IN_WIDTH  = 10,
    localparam int OUT_WIDTH = stage_width(IN_WIDTH)
) (
    input  logic [IN_WIDTH-1:0]  value,
    output logic [OUT_WIDTH-1:0] count
);

    // Scanning from the MSB down lets the lowest set bit win; a zero input yields 0.
    always_comb begin
        count = '0;
        for (int k = IN_WIDTH - 1; k >= 0; k--) begin
            if (value[k]) count = OUT_WIDTH'(k);
        end
    end

endmodule

// File: rtl/polar_sc_scheduler.sv
// SC decoding-tree walker: issues f/g commands per stage node and decides each bit from the leaf LLR.
module polar_sc_scheduler
    import polar_pkg::*;
#(
    parameter  int CODE_LENGTH        = 1024,
    parameter  int FROZEN_BITS_LENGTH = 48,
    localparam int COUNTER_WIDTH      = $clog2(CODE_LENGTH),
    localparam int STAGE_WIDTH        = stage_width(COUNTER_WIDTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     count_err,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic                     cmd_op,
    output logic [STAGE_WIDTH-1:0]   cmd_stage,
    output logic [COUNTER_WIDTH-1:0] cmd_bit_idx,
    input  logic                     llr0_valid,
    input  logic                     llr0_sign,
    input  logic                     frozen_in,
    output logic                     u_valid,
    output logic                     u_hat,
    output logic [COUNTER_WIDTH-1:0] u_idx,
    output logic                     psum_update
);

    localparam logic [COUNTER_WIDTH-1:0] LAST_IDX    = COUNTER_WIDTH'(CODE_LENGTH - 1);
    localparam logic [COUNTER_WIDTH:0]   INFO_TARGET = (COUNTER_WIDTH + 1)'(CODE_LENGTH - FROZEN_BITS_LENGTH);
    localparam logic [STAGE_WIDTH-1:0]   TOP_STAGE   = STAGE_WIDTH'(COUNTER_WIDTH - 1);

    sched_state_e             state_q, state_d;
    logic [COUNTER_WIDTH-1:0] idx_q, idx_d;
    logic [STAGE_WIDTH-1:0]   stage_q, stage_d;
    logic [COUNTER_WIDTH:0]   info_cnt_q, info_cnt_d;
    logic                     sign_q, sign_d;
    logic [STAGE_WIDTH-1:0]   restart_stage;
    polar_op_e                op_sel;

    polar_ctz #(.IN_WIDTH(COUNTER_WIDTH)) u_ctz (
        .value (idx_q + COUNTER_WIDTH'(1)),
        .count (restart_stage)
    );

    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        stage_d    = stage_q;
        info_cnt_d = info_cnt_q;
        sign_d     = sign_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d      = '0;
                    stage_d    = TOP_STAGE;
                    info_cnt_d = '0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    if (stage_q != '0) stage_d = stage_q - STAGE_WIDTH'(1);
                    else               state_d = ST_WAIT_LLR;
                end
            end
            ST_WAIT_LLR: begin
                // The sign is latched here so the decision does not depend on how long it stays driven.
                if (llr0_valid) begin
                    sign_d  = llr0_sign;
                    state_d = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                if (!frozen_in) info_cnt_d = info_cnt_q + (COUNTER_WIDTH + 1)'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_FINISH;
                end else begin
                    idx_d   = idx_q + COUNTER_WIDTH'(1);
                    stage_d = restart_stage;
                    state_d = ST_ISSUE;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            stage_q    <= '0;
            info_cnt_q <= '0;
            sign_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            stage_q    <= stage_d;
            info_cnt_q <= info_cnt_d;
            sign_q     <= sign_d;
        end
    end

    assign op_sel      = idx_q[stage_q] ? OP_G : OP_F;
    assign busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT_LLR) || (state_q == ST_DECIDE);
    assign cmd_valid   = (state_q == ST_ISSUE);
    assign cmd_op      = op_sel;
    assign cmd_stage   = stage_q;
    assign cmd_bit_idx = idx_q;
    assign u_valid     = (state_q == ST_DECIDE);
    assign psum_update = u_valid;
    assign u_hat       = u_valid && !frozen_in && sign_q;
    assign u_idx       = idx_q;
    assign done        = (state_q == ST_FINISH);
    assign count_err   = done && (info_cnt_q != INFO_TARGET);

endmodule

// File: doc/polar_sc_scheduler.md
Name: polar_sc_scheduler

Overview:
- Control unit for the successive-cancellation (SC) polar decoder.
- Walks the SC decoding tree for one CODE_LENGTH frame: issues one f/g command per stage node to the LLR datapath, then decides each bit from the stage-0 LLR sign and the frozen-bit flag.
- Emits decided bits in index order. Partial-sum updates are requested through a strobe.
- Sits between the frame-level top and the LLR/partial-sum datapath; owns no LLR storage.

Parameters:
- CODE_LENGTH, 1024, frame length N; must be a power of 2, >= 4.
- FROZEN_BITS_LENGTH, 48, number of frozen bits per frame; used only for the end-of-frame count check.
- Derived localparams: COUNTER_WIDTH = $clog2(CODE_LENGTH); STAGE_WIDTH = $clog2(COUNTER_WIDTH), minimum 1.

Ports:
- clk, in, 1, single clock.
- reset, in, 1, asynchronous, active-high; clears all state.
- start, in, 1, one-cycle pulse; begins a frame; ignored while busy.
- busy, out, 1, high from the cycle after an accepted start until done.
- done, out, 1, one-cycle pulse when the last bit is decided.
- count_err, out, 1, valid with done: info-bit count != CODE_LENGTH-FROZEN_BITS_LENGTH.
- cmd_valid, out, 1, command to datapath valid.
- cmd_ready, in, 1, datapath accepts command.
- cmd_op, out, 1, 0 = f, 1 = g.
- cmd_stage, out, STAGE_WIDTH, tree stage; COUNTER_WIDTH-1 = channel side, 0 = leaf.
- cmd_bit_idx, out, COUNTER_WIDTH, current bit index i.
- llr0_valid, in, 1, stage-0 LLR result ready (pulse).
- llr0_sign, in, 1, sign of stage-0 LLR; 1 = negative.
- frozen_in, in, 1, frozen flag for cmd_bit_idx; combinational lookup by parent, valid whenever busy.
- u_valid, out, 1, one-cycle pulse; decided bit available.
- u_hat, out, 1, decided bit value.
- u_idx, out, COUNTER_WIDTH, index of u_hat.
- psum_update, out, 1, coincident with u_valid; datapath folds u_hat into partial sums.

Behaviour:
- Reset values:
  - busy, done, count_err, cmd_valid, u_valid, psum_update, u_hat = 0.
  - cmd_op = 0; cmd_stage, cmd_bit_idx, u_idx = 0; state = IDLE.
- States: IDLE, ISSUE, WAIT_LLR, DECIDE, FINISH.
- IDLE:
  - start=1 -> i = 0, s = COUNTER_WIDTH-1, info_cnt = 0 -> ISSUE.
- ISSUE:
  - cmd_valid = 1, cmd_stage = s, cmd_op = bit s of i, cmd_bit_idx = i.
  - Outputs are held stable until cmd_ready.
  - On a handshake with s > 0: s decrements, stay in ISSUE, and the next command is issued the following cycle. Back-to-back commands are allowed.
  - On a handshake with s == 0: -> WAIT_LLR.
- WAIT_LLR:
  - cmd_valid = 0; wait for llr0_valid.
  - llr0_valid in any other state is ignored.
- DECIDE (one cycle):
  - u_hat = frozen_in ? 0 : llr0_sign; u_valid = psum_update = 1; u_idx = i.
  - info_cnt increments if !frozen_in.
  - If i == CODE_LENGTH-1 -> FINISH. Otherwise i increments and s = ctz(i+1), the trailing-zero count of the new index -> ISSUE.
- FINISH (one cycle):
  - done = 1; count_err = (info_cnt != CODE_LENGTH-FROZEN_BITS_LENGTH) -> IDLE.
  - busy drops in the same cycle as done.
- Command total per frame: exactly 2N-2; stage s receives N/2^s commands.
- Minimum frame latency, with cmd_ready = 1 and llr0_valid one cycle after the stage-0 handshake: (2N-2) + 2N + 1 cycles from start to done.
- Wrap-around: i is never incremented past N-1. ctz is evaluated only for i+1 in 1..N-1, so its result is <= COUNTER_WIDTH-1.
- start during busy: ignored, with no restart and no error.
- start in the FINISH cycle: ignored; a new frame needs start while in IDLE.
- reset mid-frame: immediate return to IDLE with reset values. No done pulse; an in-flight command is dropped.

Decomposition:
- polar_pkg holds:
  - typedef enum of op (OP_F, OP_G);
  - typedef enum of scheduler states;
  - function for STAGE_WIDTH.
- One sub-module, polar_ctz: combinational trailing-zero count, COUNTER_WIDTH in, STAGE_WIDTH out.

Test Plan:
- Order (N=8, cmd_ready=1, llr0_valid 1 cycle after leaf command, no frozen bits): the (op, stage) sequence must be:
  - F2 F1 F0 | G0 | G1 F0 | G0 | G2 F1 F0 | G0 | G1 F0 | G0
  - 14 commands total; done at cycle 31 after start.
- Decisions (N=8, frozen bits {0,1,2,4}, FROZEN_BITS_LENGTH=4, llr0_sign=1 always): u_hat = 0,0,0,1,0,1,1,1 at u_idx 0..7; count_err=0.
  - Same stimulus with FROZEN_BITS_LENGTH=3 must give count_err=1.
- Backpressure (N=8): cmd_ready toggles 1,0,0,1 repeating. The command stays stable while cmd_ready=0; the same 14 commands arrive in the same order with no duplicates.
- start abuse: start pulses at cycles 5 and 20 during a frame are ignored, giving exactly one done. A start in the FINISH cycle is ignored. A start 2 cycles after done starts a new frame beginning with F2.
- Reset: assert reset after the 6th command while in WAIT_LLR. All outputs go to 0 asynchronously; a following start gives a clean full 14-command frame.
- N=1024 default run (cmd_ready random 70%, llr0_valid random delay 1-4): 2046 commands, 1024 u_valid pulses with u_idx ascending 0..1023, exactly one done.
